// File: rtl/stream_sf_pkg.sv
// Shared types for the store-and-forward stream forwarder.
package stream_sf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sf_dpram.sv
// Simple dual-port frame buffer: one write port, combinational read address,
// registered read data that doubles as the transmit data register.
module sf_dpram #(
    parameter int DW    = 9,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_d, rd_data_q;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
    end

    // NOTE: the storage array is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_sf_fwd.sv
// Store-and-forward stream forwarder: buffers rx_dv frames, commits or drops
// them at frame end, and replays committed frames as gap-separated tx bursts.
module stream_sf_fwd
    import stream_sf_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 64,
    parameter int MIN_LEN = 2,
    parameter int IFG     = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    rxd,
    input  logic             rx_dv,
    output logic [DW-1:0]    txd,
    output logic             tx_en,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             drop_ovf,
    output logic             drop_runt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MIN_LEN + 1);
    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

    logic            hold_vld_d, hold_vld_q;
    logic [DW-1:0]   hold_data_d, hold_data_q;
    logic [LW-1:0]   len_d, len_q;
    logic            ovf_d, ovf_q;
    logic [PW-1:0]   wr_ptr_d, wr_ptr_q, cmt_ptr_d, cmt_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [PW-1:0]   frm_avail_d, frm_avail_q;
    tx_state_e       state_d, state_q;
    logic [GW-1:0]   gap_cnt_d, gap_cnt_q;
    logic            tx_en_d, tx_en_q;
    logic [CNT_W-1:0] ok_cnt_d, ok_cnt_q, drop_cnt_d, drop_cnt_q;
    logic            drop_ovf_d, drop_ovf_q, drop_runt_d, drop_runt_q;

    logic            frame_end, full, wr_en, wr_ovf, commit, start, rd_en, rd_last;
    logic [DW:0]     rd_data;

    assign frame_end = hold_vld_q & ~rx_dv;
    assign full      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    // Once a frame has overflowed, every later word of it is suppressed.
    assign wr_en     = hold_vld_q & ~ovf_q & ~full;
    assign wr_ovf    = hold_vld_q & ~ovf_q & full;
    assign rd_last   = rd_data[DW];

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        len_d       = len_q;
        ovf_d       = ovf_q | wr_ovf;
        wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        ok_cnt_d    = ok_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        drop_ovf_d  = 1'b0;
        drop_runt_d = 1'b0;
        commit      = 1'b0;

        if (rx_dv) begin
            hold_vld_d  = 1'b1;
            hold_data_d = rxd;
            if (len_q != LW'(MIN_LEN)) len_d = len_q + LW'(1);
        end

        if (frame_end) begin
            hold_vld_d = 1'b0;
            len_d      = '0;
            ovf_d      = 1'b0;
            if (ovf_q | wr_ovf) begin
                wr_ptr_d   = cmt_ptr_q;
                drop_ovf_d = 1'b1;
                if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else if (len_q < LW'(MIN_LEN)) begin
                wr_ptr_d    = cmt_ptr_q;
                drop_runt_d = 1'b1;
                if (~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else begin
                cmt_ptr_d = wr_ptr_q + PW'(1);
                commit    = 1'b1;
                if (~&ok_cnt_q) ok_cnt_d = ok_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        tx_en_d   = tx_en_q;
        rd_ptr_d  = rd_ptr_q;
        rd_en     = 1'b0;
        start     = 1'b0;

        case (state_q)
            IDLE: start = (frm_avail_q != '0);
            SEND: begin
                if (rd_last) begin
                    tx_en_d   = 1'b0;
                    state_d   = GAP;
                    gap_cnt_d = GW'(IFG - 1);
                end else begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
            GAP: begin
                // Leaving GAP straight into a new frame keeps the low time at exactly IFG.
                if (gap_cnt_q == '0) begin
                    start   = (frm_avail_q != '0);
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            tx_en_d  = 1'b1;
            state_d  = SEND;
        end

        case ({commit, start})
            2'b10:   frm_avail_d = frm_avail_q + PW'(1);
            2'b01:   frm_avail_d = frm_avail_q - PW'(1);
            default: frm_avail_d = frm_avail_q;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            frm_avail_q <= '0;
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            tx_en_q     <= 1'b0;
            ok_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            drop_ovf_q  <= 1'b0;
            drop_runt_q <= 1'b0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frm_avail_q <= frm_avail_d;
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_en_q     <= tx_en_d;
            ok_cnt_q    <= ok_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_ovf_q  <= drop_ovf_d;
            drop_runt_q <= drop_runt_d;
        end
    end

    sf_dpram #(
        .DW    (DW + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({frame_end, hold_data_q}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign txd       = rd_data[DW-1:0];
    assign tx_en     = tx_en_q;
    assign ok_cnt    = ok_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign drop_ovf  = drop_ovf_q;
    assign drop_runt = drop_runt_q;

endmodule

// File: tb/tb_stream_sf_fwd.sv
// Directed bench for stream_sf_fwd: a negedge monitor records tx bursts, gaps
// and drop pulses; the main sequence checks them against hand-derived values.
module tb_stream_sf_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic [7:0]  txd;
    logic        tx_en;
    logic [15:0] ok_cnt, drop_cnt;
    logic        drop_ovf, drop_runt;

    stream_sf_fwd #(
        .DW(8), .DEPTH(64), .MIN_LEN(2), .IFG(2), .CNT_W(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_dv     (rx_dv),
        .txd       (txd),
        .tx_en     (tx_en),
        .ok_cnt    (ok_cnt),
        .drop_cnt  (drop_cnt),
        .drop_ovf  (drop_ovf),
        .drop_runt (drop_runt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_q[$];
    int         burst_q[$];
    int         gap_q[$];
    int         rise_q[$];
    int         ovf_pulses = 0;
    int         runt_pulses = 0;
    bit         prev_en = 1'b0;
    int         run_len = 0;
    int         low_run = 0;

    always @(negedge clk) begin
        if (drop_ovf)  ovf_pulses++;
        if (drop_runt) runt_pulses++;
        if (tx_en === 1'b1) begin
            if (!prev_en) begin
                gap_q.push_back(low_run);
                rise_q.push_back(int'(cyc));
                run_len = 0;
            end
            tx_q.push_back(txd);
            run_len++;
            low_run = 0;
        end else begin
            if (prev_en) burst_q.push_back(run_len);
            low_run++;
        end
        prev_en = (tx_en === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        tx_q.delete();
        burst_q.delete();
        gap_q.delete();
        rise_q.delete();
        ovf_pulses  = 0;
        runt_pulses = 0;
    endtask

    task automatic send_frame(input logic [7:0] d[$], output int end_cyc);
        for (int i = 0; i < d.size(); i++) begin
            @(negedge clk);
            rxd   = d[i];
            rx_dv = 1'b1;
        end
        @(negedge clk);
        rx_dv   = 1'b0;
        rxd     = '0;
        end_cyc = int'(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, tx_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < tx_q.size()) check({tag, "_data"}, tx_q[i], exp[i]);
        end
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] d2[$];
        logic [7:0] exp[$];
        int         e_cyc;
        int         bad_bursts;
        bit         seen;

        rst_n = 1'b0;
        rx_dv = 1'b0;
        rxd   = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_en", tx_en, 0);
        check("rst_txd", txd, 0);
        check("rst_ok_cnt", ok_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_pulses", {drop_ovf, drop_runt}, 0);
        rst_n = 1'b1;
        idle(2);
        clear_mon();

        // Single 4-word frame: tx_en rises after the edge following the commit edge
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(d, e_cyc);
        idle(15);
        check_stream("t1_stream", d);
        check("t1_bursts", burst_q.size(), 1);
        check("t1_burst_len", (burst_q.size() > 0) ? burst_q[0] : -1, 4);
        check("t1_latency", (rise_q.size() > 0) ? rise_q[0] : -1, e_cyc + 2);
        check("t1_ok_cnt", ok_cnt, 1);
        check("t1_drop_cnt", drop_cnt, 0);

        // Runt frame then a minimum-length frame
        clear_mon();
        d = '{8'hA5};
        send_frame(d, e_cyc);
        idle(10);
        check("t2_runt_pulses", runt_pulses, 1);
        check("t2_runt_no_tx", tx_q.size(), 0);
        check("t2_drop_cnt", drop_cnt, 1);
        check("t2_ok_cnt_hold", ok_cnt, 1);
        clear_mon();
        d = '{8'h01, 8'h02};
        send_frame(d, e_cyc);
        idle(12);
        check_stream("t2_stream", d);
        check("t2_ok_cnt", ok_cnt, 2);

        // 70-word frame overflows the 64-entry buffer
        clear_mon();
        d.delete();
        for (int i = 0; i < 70; i++) d.push_back(8'(i + 8'h80));
        send_frame(d, e_cyc);
        idle(10);
        check("t3_ovf_pulses", ovf_pulses, 1);
        check("t3_runt_pulses", runt_pulses, 0);
        check("t3_no_tx", tx_q.size(), 0);
        check("t3_drop_cnt", drop_cnt, 2);
        clear_mon();
        d = '{8'hC1, 8'hC2, 8'hC3};
        send_frame(d, e_cyc);
        idle(12);
        check_stream("t3_stream", d);
        check("t3_ok_cnt", ok_cnt, 3);

        // Two 5-word frames one idle cycle apart: bursts separated by exactly IFG
        clear_mon();
        d  = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
        d2 = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
        send_frame(d, e_cyc);
        send_frame(d2, e_cyc);
        idle(30);
        exp = {d, d2};
        check_stream("t4_stream", exp);
        check("t4_bursts", burst_q.size(), 2);
        check("t4_burst0", (burst_q.size() > 0) ? burst_q[0] : -1, 5);
        check("t4_burst1", (burst_q.size() > 1) ? burst_q[1] : -1, 5);
        check("t4_gap", (gap_q.size() > 1) ? gap_q[1] : -1, 2);
        check("t4_ok_cnt", ok_cnt, 5);

        // Sixteen 4-word frames totalling DEPTH words
        clear_mon();
        exp.delete();
        for (int f = 0; f < 16; f++) begin
            d.delete();
            for (int w = 0; w < 4; w++) d.push_back(8'(f * 16 + w));
            exp = {exp, d};
            send_frame(d, e_cyc);
        end
        idle(60);
        check_stream("t5_stream", exp);
        check("t5_bursts", burst_q.size(), 16);
        bad_bursts = 0;
        foreach (burst_q[i]) if (burst_q[i] != 4) bad_bursts++;
        check("t5_burst_lens", bad_bursts, 0);
        check("t5_ok_cnt", ok_cnt, 21);
        check("t5_drop_cnt", drop_cnt, 2);
        check("t5_no_drop_pulses", ovf_pulses + runt_pulses, 0);

        // Reset pulse while a frame is being sent
        clear_mon();
        d.delete();
        for (int i = 0; i < 10; i++) d.push_back(8'(8'hE0 + i));
        send_frame(d, e_cyc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_en === 1'b1) seen = 1'b1;
        end
        check("t6_sending", seen, 1);
        idle(2);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_tx_en", tx_en, 0);
        check("t6_rst_txd", txd, 0);
        check("t6_rst_ok_cnt", ok_cnt, 0);
        check("t6_rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        idle(3);
        clear_mon();
        d = '{8'hD1, 8'hD2, 8'hD3};
        send_frame(d, e_cyc);
        idle(12);
        check_stream("t6_stream", d);
        check("t6_ok_cnt", ok_cnt, 1);
        check("t6_drop_cnt", drop_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
